fifo_rr_drain_arbiter: RTL

//  Drains up to NumReq show-head SYNCFIFO instances (ShowHead=1) onto one registered output stream.

---
 rtl/fifo_rr_drain_arbiter.sv | 124 ++++++++++++
 1 files changed

// File: rtl/fifo_rr_drain_arbiter.sv
// Round-robin drain arbiter for show-head FIFOs.
// Bursts of up to MaxBurst words per grant onto one registered stream.
module fifo_rr_drain_arbiter #(
    parameter int NumReq     = 4,
    parameter int DataWidth  = 32,
    parameter int IdxWidth   = 2,
    parameter int MaxBurst   = 4,
    parameter int BurstWidth = 3
) (
    input  logic                        CLK,
    input  logic                        Rest,
    input  logic                        Enable,
    input  logic [NumReq-1:0]           ReqNotEmpty,
    input  logic [NumReq*DataWidth-1:0] ReqData,
    output logic [NumReq-1:0]           ReqRead,
    output logic [NumReq-1:0]           Grant,
    output logic [DataWidth-1:0]        OutData,
    output logic [IdxWidth-1:0]         OutSrc,
    output logic                        OutLast,
    output logic                        OutValid,
    input  logic                        OutReady
);

    typedef enum logic {
        StIdle,
        StBurst
    } state_t;

    localparam logic [BurstWidth-1:0] LastCount = BurstWidth'(MaxBurst - 1);
    localparam logic [IdxWidth-1:0]   LastIdx   = IdxWidth'(NumReq - 1);
    localparam logic [NumReq-1:0]     OneHot0   = NumReq'(1);

    state_t                state;
    logic [IdxWidth-1:0]   owner;
    logic [IdxWidth-1:0]   last_grant;
    logic [IdxWidth-1:0]   pick;
    logic                  pick_vld;
    logic [BurstWidth-1:0] count;
    logic                  load;
    logic                  pop;
    logic                  burst_end;
    logic [DataWidth-1:0]  head;

    assign load = ~OutValid | OutReady;
    assign head = ReqData[int'(owner)*DataWidth +: DataWidth];
    assign pop  = (state == StBurst) & ~Rest & load & ReqNotEmpty[owner];

    // A burst ends on its MaxBurst-th pop or as soon as the owner runs dry.
    assign burst_end = (pop & (count == LastCount)) | ~ReqNotEmpty[owner];

    // Read strobe goes only to the current owner, and only when a word moves.
    always_comb begin
        ReqRead = '0;
        if (pop) begin
            ReqRead[owner] = 1'b1;
        end
    end

    // Rotating priority scan: offset 1 from last_grant is highest priority.
    always_comb begin
        int idx;
        idx      = 0;
        pick     = last_grant;
        pick_vld = 1'b0;
        for (int k = NumReq; k >= 1; k--) begin
            idx = (int'(last_grant) + k) % NumReq;
            if (ReqNotEmpty[idx]) begin
                pick     = IdxWidth'(idx);
                pick_vld = 1'b1;
            end
        end
    end

    // Grant/burst FSM with registered output stage.
    always_ff @(posedge CLK) begin
        if (Rest) begin
            state      <= StIdle;
            Grant      <= '0;
            owner      <= '0;
            last_grant <= LastIdx;
            count      <= '0;
            OutValid   <= 1'b0;
            OutData    <= '0;
            OutSrc     <= '0;
            OutLast    <= 1'b0;
        end else begin
            unique case (state)
                StIdle: begin
                    if (load) begin
                        OutValid <= 1'b0;
                        OutLast  <= 1'b0;
                    end
                    if (Enable && pick_vld) begin
                        Grant <= OneHot0 << pick;
                        owner <= pick;
                        count <= '0;
                        state <= StBurst;
                    end
                end
                StBurst: begin
                    if (pop) begin
                        OutData  <= head;
                        OutSrc   <= owner;
                        OutValid <= 1'b1;
                        OutLast  <= (count == LastCount);
                        count    <= count + BurstWidth'(1);
                    end else if (load) begin
                        OutValid <= 1'b0;
                        OutLast  <= 1'b0;
                    end
                    if (burst_end) begin
                        state      <= StIdle;
                        Grant      <= '0;
                        last_grant <= owner;
                    end
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

endmodule
